// File: rtl/mdu_div_ctrl.sv
// mdu_div_ctrl: sequencing controller between EX and the iterative divider pair.
// Owns HI/LO, launches the divider with a one-cycle start pulse, writes the
// quotient/remainder back on completion and interlocks the pipeline meanwhile.
// Optional feature macro: MDU_DIV0_BYPASS_EN (divide-by-zero resolved in IDLE).
module mdu_div_ctrl #(
   parameter int unsigned WAIT_MAX = 2
) (
   input  logic        clock,
   input  logic        resetn,
   input  logic        issue_en,
   input  logic        op_div,
   input  logic        op_divu,
   input  logic        op_mfhi,
   input  logic        op_mflo,
   input  logic        op_mthi,
   input  logic        op_mtlo,
   input  logic [31:0] rs_val,
   input  logic [31:0] rt_val,
   input  logic        flush,
   input  logic        div_busy,
   input  logic [31:0] div_q,
   input  logic [31:0] div_r,
   output logic [31:0] div_a,
   output logic [31:0] div_b,
   output logic        div_sign,
   output logic        div_start,
   output logic [31:0] hi,
   output logic [31:0] lo,
   output logic [31:0] mf_data,
   output logic        stall,
   output logic        div0_flag
);

   localparam int unsigned CntW = (WAIT_MAX > 1) ? $clog2(WAIT_MAX) : 1;
   localparam logic [CntW-1:0] CntLast = CntW'((WAIT_MAX > 0) ? WAIT_MAX - 1 : 0);

   typedef enum logic [1:0] {
      StIdle,
      StLaunch,
      StWait,
      StRun
   } state_e;

   state_e            state_q, state_d;
   logic [31:0]       hi_q, hi_d;
   logic [31:0]       lo_q, lo_d;
   logic [31:0]       div_a_q, div_a_d;
   logic [31:0]       div_b_q, div_b_d;
   logic              div_sign_q, div_sign_d;
   logic              div_start_q, div_start_d;
   logic              discard_q, discard_d;
   logic [CntW-1:0]   wait_cnt_q, wait_cnt_d;
   logic              div0_flag_d;

   logic is_div;
   logic mdu_op;
   logic accept;

   assign is_div = op_div | op_divu;
   assign mdu_op = is_div | op_mfhi | op_mflo | op_mthi | op_mtlo;

   // Only MDU instructions are held while a division is in flight.
   assign stall   = (state_q != StIdle) & issue_en & mdu_op;
   assign accept  = (state_q == StIdle) & issue_en & is_div & ~flush & ~stall;
   assign mf_data = op_mfhi ? hi_q : lo_q;

   // Next-state, HI/LO update and divider launch decisions.
   always_comb begin
      state_d     = state_q;
      hi_d        = hi_q;
      lo_d        = lo_q;
      div_a_d     = div_a_q;
      div_b_d     = div_b_q;
      div_sign_d  = div_sign_q;
      div_start_d = 1'b0;
      discard_d   = discard_q;
      wait_cnt_d  = wait_cnt_q;
      div0_flag_d = 1'b0;

      case (state_q)
         StIdle: begin
            if (accept) begin
`ifdef MDU_DIV0_BYPASS_EN
               if (rt_val == 32'd0) begin
                  // Resolved locally; the divider is never started.
                  lo_d        = 32'hFFFF_FFFF;
                  hi_d        = rs_val;
                  div0_flag_d = 1'b1;
               end else begin
                  div_a_d     = rs_val;
                  div_b_d     = rt_val;
                  div_sign_d  = op_div;
                  div_start_d = 1'b1;
                  discard_d   = 1'b0;
                  wait_cnt_d  = '0;
                  state_d     = StLaunch;
               end
`else
               div_a_d     = rs_val;
               div_b_d     = rt_val;
               div_sign_d  = op_div;
               div_start_d = 1'b1;
               discard_d   = 1'b0;
               wait_cnt_d  = '0;
               state_d     = StLaunch;
`endif
            end else if (issue_en && !flush && !is_div && op_mthi) begin
               hi_d = rs_val;
            end else if (issue_en && !flush && !is_div && op_mtlo) begin
               lo_d = rs_val;
            end
         end

         StLaunch: begin
            if (flush) discard_d = 1'b1;
            wait_cnt_d = '0;
            state_d    = StWait;
         end

         StWait: begin
            if (flush) discard_d = 1'b1;
            if (div_busy || (wait_cnt_q == CntLast)) begin
               // Never wait forever on a divider that misses the start pulse.
               wait_cnt_d = '0;
               state_d    = StRun;
            end else begin
               wait_cnt_d = wait_cnt_q + CntW'(1);
            end
         end

         StRun: begin
            if (flush) discard_d = 1'b1;
            if (!div_busy) begin
               // A flush landing on the completion cycle also squashes the result.
               if (!discard_q && !flush) begin
                  lo_d = div_q;
                  hi_d = div_r;
               end
               discard_d = 1'b0;
               state_d   = StIdle;
            end
         end

         default: state_d = StIdle;
      endcase
   end

   // State register with synchronous active-high reset.
   always_ff @(posedge clock) begin
      if (resetn) begin
         state_q     <= StIdle;
         hi_q        <= '0;
         lo_q        <= '0;
         div_a_q     <= '0;
         div_b_q     <= '0;
         div_sign_q  <= 1'b0;
         div_start_q <= 1'b0;
         discard_q   <= 1'b0;
         wait_cnt_q  <= '0;
      end else begin
         state_q     <= state_d;
         hi_q        <= hi_d;
         lo_q        <= lo_d;
         div_a_q     <= div_a_d;
         div_b_q     <= div_b_d;
         div_sign_q  <= div_sign_d;
         div_start_q <= div_start_d;
         discard_q   <= discard_d;
         wait_cnt_q  <= wait_cnt_d;
      end
   end

`ifdef MDU_DIV0_BYPASS_EN
   logic div0_flag_q;

   // One-cycle divide-by-zero indication.
   always_ff @(posedge clock) begin
      if (resetn) begin
         div0_flag_q <= 1'b0;
      end else begin
         div0_flag_q <= div0_flag_d;
      end
   end

   assign div0_flag = div0_flag_q;
`else
   logic unused_div0;
   assign unused_div0 = div0_flag_d;
   assign div0_flag   = 1'b0;
`endif

   assign div_a     = div_a_q;
   assign div_b     = div_b_q;
   assign div_sign  = div_sign_q;
   assign div_start = div_start_q;
   assign hi        = hi_q;
   assign lo        = lo_q;

endmodule

// File: tb/tb_mdu_div_ctrl.sv
// Testbench for mdu_div_ctrl with a behavioural divider model.
module tb_mdu_div_ctrl;

   localparam int unsigned WaitMax = 2;
   localparam int          Lat     = 6;
   localparam int          NormCyc = Lat + 2;
   localparam int          NoBusyCyc = WaitMax + 2;

   localparam logic [1:0] KMthi = 2'd0;
   localparam logic [1:0] KMtlo = 2'd1;
   localparam logic [1:0] KDiv  = 2'd2;
   localparam logic [1:0] KDivu = 2'd3;

   logic        clock = 1'b0;
   logic        resetn;
   logic        issue_en, op_div, op_divu, op_mfhi, op_mflo, op_mthi, op_mtlo;
   logic [31:0] rs_val, rt_val;
   logic        flush;
   logic        div_busy;
   logic [31:0] div_q, div_r;
   logic [31:0] div_a, div_b;
   logic        div_sign, div_start;
   logic [31:0] hi, lo, mf_data;
   logic        stall, div0_flag;

   always #5 clock = ~clock;

   mdu_div_ctrl #(.WAIT_MAX(WaitMax)) dut (
      .clock     (clock),
      .resetn    (resetn),
      .issue_en  (issue_en),
      .op_div    (op_div),
      .op_divu   (op_divu),
      .op_mfhi   (op_mfhi),
      .op_mflo   (op_mflo),
      .op_mthi   (op_mthi),
      .op_mtlo   (op_mtlo),
      .rs_val    (rs_val),
      .rt_val    (rt_val),
      .flush     (flush),
      .div_busy  (div_busy),
      .div_q     (div_q),
      .div_r     (div_r),
      .div_a     (div_a),
      .div_b     (div_b),
      .div_sign  (div_sign),
      .div_start (div_start),
      .hi        (hi),
      .lo        (lo),
      .mf_data   (mf_data),
      .stall     (stall),
      .div0_flag (div0_flag)
   );

   // Behavioural divider: busy for Lat cycles after the start edge.
   logic        m_busy;
   int          m_cnt;
   logic [31:0] m_q, m_r;
   logic        no_busy;
   int          n_starts;
   int          n_flags;

   assign div_busy = m_busy;
   assign div_q    = m_q;
   assign div_r    = m_r;

   always @(posedge clock) begin
      if (resetn) begin
         m_busy <= 1'b0;
         m_cnt  <= 0;
      end else if (div_start) begin
         if (div_b == 32'd0) begin
            m_q <= 32'hFFFF_FFFF;
            m_r <= div_a;
         end else if (div_sign) begin
            m_q <= 32'($signed(div_a) / $signed(div_b));
            m_r <= 32'($signed(div_a) % $signed(div_b));
         end else begin
            m_q <= div_a / div_b;
            m_r <= div_a % div_b;
         end
         m_busy <= ~no_busy;
         m_cnt  <= Lat;
      end else if (m_busy) begin
         if (m_cnt == 1) m_busy <= 1'b0;
         m_cnt <= m_cnt - 1;
      end
   end

   always @(posedge clock) begin
      if (div_start) n_starts <= n_starts + 1;
      if (div0_flag) n_flags <= n_flags + 1;
   end

   typedef struct {
      logic [1:0]  kind;
      logic [31:0] rs;
      logic [31:0] rt;
      logic [31:0] exp_hi;
      logic [31:0] exp_lo;
      logic        exp_sign;
      int          exp_cyc;
   } vec_t;

   int n_vec = 0;
   int n_err = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %h, want %h", name, act, exp);
      end
   endtask

   task automatic clear_ops();
      issue_en = 1'b0; op_div = 1'b0; op_divu = 1'b0; op_mfhi = 1'b0;
      op_mflo = 1'b0; op_mthi = 1'b0; op_mtlo = 1'b0; flush = 1'b0;
   endtask

   // Presents one instruction for one cycle; returns just after the next negedge.
   task automatic issue(input logic [1:0] kind, input logic [31:0] rs, input logic [31:0] rt,
                        input logic fl);
      @(negedge clock);
      clear_ops();
      issue_en = 1'b1;
      flush    = fl;
      rs_val   = rs;
      rt_val   = rt;
      case (kind)
         KMthi:   op_mthi = 1'b1;
         KMtlo:   op_mtlo = 1'b1;
         KDiv:    op_div  = 1'b1;
         default: op_divu = 1'b1;
      endcase
      @(negedge clock);
      clear_ops();
      #1;
   endtask

   // Holds an MFLO in EX and counts stalled cycles until it proceeds.
   task automatic wait_done(output int cyc);
      cyc = 0;
      issue_en = 1'b1;
      op_mflo  = 1'b1;
      #1;
      while (stall && cyc < 200) begin
         cyc++;
         @(negedge clock);
         #1;
      end
      check("stall_timeout", {31'd0, stall}, 32'd0);
      clear_ops();
      #1;
   endtask

   task automatic wait_busy();
      for (int i = 0; i < 20 && !m_busy; i++) begin
         @(negedge clock);
         #1;
      end
      check("busy_seen", {31'd0, m_busy}, 32'd1);
   endtask

   task automatic probe_hilo(input logic [31:0] exp_hi, input logic [31:0] exp_lo);
      check("hi", hi, exp_hi);
      check("lo", lo, exp_lo);
      issue_en = 1'b1;
      op_mfhi  = 1'b1;
      #1;
      check("mfhi_data", mf_data, exp_hi);
      check("mf_stall", {31'd0, stall}, 32'd0);
      op_mfhi = 1'b0;
      op_mflo = 1'b1;
      #1;
      check("mflo_data", mf_data, exp_lo);
      clear_ops();
      #1;
   endtask

   task automatic apply(input vec_t v);
      int s0;
      int cyc;
      s0 = n_starts;
      issue(v.kind, v.rs, v.rt, 1'b0);
      if (v.kind == KDiv || v.kind == KDivu) begin
         check("div_start", {31'd0, div_start}, 32'd1);
         check("div_sign", {31'd0, div_sign}, {31'd0, v.exp_sign});
         check("div_a", div_a, v.rs);
         check("div_b", div_b, v.rt);
         wait_done(cyc);
         check("stall_cycles", cyc, v.exp_cyc);
         check("start_count", n_starts - s0, 32'd1);
      end else begin
         check("start_count", n_starts - s0, 32'd0);
      end
      probe_hilo(v.exp_hi, v.exp_lo);
   endtask

   vec_t vecs[5];

   initial begin
      int s0;
      int cyc;
      vecs[0] = '{KMthi, 32'h0000_1234, 32'h0, 32'h0000_1234, 32'h0000_0000, 1'b0, 0};
      vecs[1] = '{KDiv,  32'hFFFF_FFF9, 32'h2, 32'hFFFF_FFFF, 32'hFFFF_FFFD, 1'b1, NormCyc};
      vecs[2] = '{KDivu, 32'hFFFF_FFFF, 32'h10, 32'h0000_000F, 32'h0FFF_FFFF, 1'b0, NormCyc};
      vecs[3] = '{KMthi, 32'h0000_AAAA, 32'h0, 32'h0000_AAAA, 32'h0FFF_FFFF, 1'b0, 0};
      vecs[4] = '{KMtlo, 32'h0000_5555, 32'h0, 32'h0000_AAAA, 32'h0000_5555, 1'b0, 0};

      n_starts = 0;
      n_flags  = 0;
      no_busy  = 1'b0;
      rs_val   = '0;
      rt_val   = '0;
      clear_ops();
      resetn = 1'b1;
      repeat (2) @(negedge clock);
      resetn = 1'b0;
      #1;
      check("rst_hi", hi, 32'd0);
      check("rst_lo", lo, 32'd0);
      check("rst_div_start", {31'd0, div_start}, 32'd0);
      check("rst_div0_flag", {31'd0, div0_flag}, 32'd0);
      check("rst_div_a", div_a, 32'd0);

      for (int i = 0; i < 5; i++) apply(vecs[i]);

      // Non-MDU instruction proceeds during RUN; flush squashes the writeback.
      issue(KDiv, 32'd100, 32'd7, 1'b0);
      wait_busy();
      issue_en = 1'b1;
      #1;
      check("non_mdu_stall", {31'd0, stall}, 32'd0);
      flush = 1'b1;
      @(negedge clock);
      flush = 1'b1;
      @(negedge clock);
      clear_ops();
      #1;
      wait_done(cyc);
      probe_hilo(32'h0000_AAAA, 32'h0000_5555);
      apply('{KDiv, 32'd100, 32'd7, 32'd2, 32'd14, 1'b1, NormCyc});

      // Flush in IDLE suppresses both an accept and an MT write.
      s0 = n_starts;
      issue(KDiv, 32'd9, 32'd3, 1'b1);
      check("flush_idle_start", {31'd0, div_start}, 32'd0);
      issue(KMthi, 32'h77, 32'd0, 1'b1);
      check("flush_idle_starts", n_starts - s0, 32'd0);
      probe_hilo(32'd2, 32'd14);

      // Divider that never raises busy: WAIT times out into RUN.
      no_busy = 1'b1;
      apply('{KDivu, 32'd50, 32'd8, 32'd2, 32'd6, 1'b0, NoBusyCyc});
      no_busy = 1'b0;

      // Reset mid-RUN abandons the division; a new one is accepted at once.
      issue(KDiv, 32'd100, 32'd7, 1'b0);
      wait_busy();
      resetn = 1'b1;
      @(negedge clock);
      resetn = 1'b0;
      #1;
      check("midrst_div_start", {31'd0, div_start}, 32'd0);
      probe_hilo(32'd0, 32'd0);
      apply('{KDiv, 32'd100, 32'd7, 32'd2, 32'd14, 1'b1, NormCyc});

`ifdef MDU_DIV0_BYPASS_EN
      s0 = n_starts;
      issue(KDiv, 32'h55, 32'd0, 1'b0);
      check("div0_start", {31'd0, div_start}, 32'd0);
      check("div0_flag_on", {31'd0, div0_flag}, 32'd1);
      probe_hilo(32'h55, 32'hFFFF_FFFF);
      @(negedge clock);
      #1;
      check("div0_flag_off", {31'd0, div0_flag}, 32'd0);
      check("div0_starts", n_starts - s0, 32'd0);
      check("div0_flag_count", n_flags, 32'd1);
`else
      apply('{KDiv, 32'h55, 32'd0, 32'h55, 32'hFFFF_FFFF, 1'b1, NormCyc});
      check("div0_flag_count", n_flags, 32'd0);
`endif

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule

// File: doc/mdu_div_ctrl.md
Name: mdu_div_ctrl

Overview:
- Sequencing controller between the EX stage and the iterative divider pair (signed wrapper and unsigned core) for MIPS DIV/DIVU.
- Owns the architectural HI/LO registers and launches the divider with a one-cycle start pulse.
- Tracks divider busy, writes the quotient to LO and the remainder to HI, and services MFHI/MFLO/MTHI/MTLO.
- Generates the pipeline stall interlock while a division is in flight.

Parameters:
- WAIT_MAX, 2: cycles to wait in WAIT for div_busy to rise before forcing RUN.

Ports:
- clock  in  1  system clock, all state on rising edge
- resetn  in  1  reset, synchronous, active-high
- issue_en  in  1  EX-stage instruction valid this cycle
- op_div  in  1  signed divide
- op_divu  in  1  unsigned divide
- op_mfhi  in  1  read HI
- op_mflo  in  1  read LO
- op_mthi  in  1  write HI from rs_val
- op_mtlo  in  1  write LO from rs_val
- rs_val  in  32  dividend / MT source
- rt_val  in  32  divisor
- flush  in  1  squash the EX instruction and any in-flight division result
- div_busy  in  1  divider busy (muxed by div_sign externally)
- div_q  in  32  divider quotient
- div_r  in  32  divider remainder
- div_a  out  32  registered dividend to divider
- div_b  out  32  registered divisor to divider
- div_sign  out  1  1 = signed unit, 0 = unsigned unit
- div_start  out  1  registered one-cycle start pulse
- hi  out  32  HI register
- lo  out  32  LO register
- mf_data  out  32  op_mfhi ? hi : lo, combinational
- stall  out  1  combinational pipeline hold
- div0_flag  out  1  divide-by-zero pulse, only with the optional feature

Behaviour:
- Reset (resetn=1 at edge, any state):
  - Forces state IDLE.
  - Clears hi, lo, div_a, div_b, div_sign, div_start, discard flag, wait counter and div0_flag to 0.
  - A reset mid-division abandons the result; the divider shares resetn.
- States:
  - IDLE:
    - Accept when issue_en & (op_div|op_divu) & !flush & !stall.
    - On accept: latch div_a=rs_val, div_b=rt_val, div_sign=op_div; go to LAUNCH.
    - MTHI/MTLO with issue_en & !flush write hi/lo=rs_val at the next edge.
  - LAUNCH: div_start=1 for exactly this cycle; go to WAIT.
  - WAIT:
    - div_busy=1 goes to RUN.
    - Otherwise increment the counter; after WAIT_MAX cycles go to RUN anyway.
  - RUN:
    - Stay while div_busy=1.
    - The first cycle with div_busy=0 is completion: if discard=0, lo<=div_q and hi<=div_r at that edge.
    - Clear discard; go to IDLE.
- Latency: accept at edge N; div_start high in N+1; HI/LO valid the cycle after the completion edge. This is 32-bit divider latency plus 3 cycles minimum.
- div_start is never asserted outside LAUNCH.
- stall = (state != IDLE) & issue_en & (op_div|op_divu|op_mfhi|op_mflo|op_mthi|op_mtlo). Other instructions proceed.
- Completion cycle: stall is still asserted because state is RUN. The stalled MF sees the new HI/LO in the following IDLE cycle.
- flush:
  - In IDLE, flush suppresses the accept or MT write of the same cycle.
  - In LAUNCH/WAIT/RUN, flush sets discard. The state sequence continues so the divider is drained cleanly, and the HI/LO writeback is suppressed.
  - Repeated flushes are idempotent.
- Simultaneous MT and DIV cannot occur, since a single instruction is presented per cycle. If multiple op bits are set, priority is div > divu > mthi > mtlo.
- Arithmetic semantics (sign fixup, remainder sign = dividend sign) belong to the divider. The controller only routes 32-bit values.

Optional Feature:
- Macro: MDU_DIV0_BYPASS_EN
- With the macro defined:
  - An accept with rt_val==0 does not enter LAUNCH and no div_start is issued.
  - Next edge: lo<=32'hFFFFFFFF, hi<=rs_val, div0_flag=1 for one cycle; state stays IDLE.
- Without the macro:
  - Divide-by-zero runs through the divider like any other operand, and HI/LO take whatever it returns.
  - div0_flag is tied to 0.

Test Plan:
- Reset, then MTHI rs=0x00001234, then MFHI -> mf_data=0x00001234, stall=0; lo remains 0.
- DIV rs=0xFFFFFFF9 (-7), rt=2, with the behavioural divider -> single div_start pulse, div_sign=1.
  - MFLO issued during RUN -> stall=1 until completion.
  - Result: lo=0xFFFFFFFD, hi=0xFFFFFFFF.
- DIVU rs=0xFFFFFFFF, rt=0x10 -> div_sign=0, lo=0x0FFFFFFF, hi=0x0000000F.
- Preload hi=0xAAAA, lo=0x5555, then DIV 100/7 with flush pulsed in RUN -> hi/lo unchanged, state returns IDLE after busy drops; a following DIV 100/7 gives lo=14, hi=2.
- resetn pulsed mid-RUN -> next cycle hi=lo=0, div_start=0, stall=0; a new DIV is accepted immediately.
- DIV rs=0x55, rt=0:
  - With MDU_DIV0_BYPASS_EN: no div_start, lo=0xFFFFFFFF, hi=0x55, div0_flag one cycle.
  - Without the macro: div_start pulses once.
